// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory arbiter slice.
//   owner_e     : which requester owns the read data returning this cycle
//   AGE_MAX_DEF : default starvation limit for the debug requester
//   WORD_LSB    : lowest byte-address bit that selects a RAM word
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_MEM  = 2'd2,
      OWN_DBG  = 2'd3
   } owner_e;

   localparam int AGE_MAX_DEF = 8;
   localparam int WORD_LSB    = 2;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Requester-side buses of the memory arbiter: the instruction-fetch read
// port and the MEM-stage load/store port.
//   master : the pipeline side, drives requests, receives grants/read data
//   slave  : the arbiter side, receives requests, drives grants/read data
// Parameters ADDR_W / DATA_W : byte-address and data widths.
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/mem_arb_age.sv
// ---------------------------------------------------------------------------
// mem_arb_age
// Saturating starvation counter for the debug requester.
//   clk    : clock, rising edge
//   rst    : synchronous active-low reset, clears the count
//   clr    : debug was granted this cycle, restart from zero
//   inc    : debug was passed over this cycle, count up (saturating)
//   at_max : count has reached AGE_MAX, debug must win over fetch
// Parameter AGE_MAX : starvation limit, 1..255.
// ---------------------------------------------------------------------------
module mem_arb_age #(
   parameter int AGE_MAX = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic at_max
);

   localparam logic [7:0] AGE_LIM = 8'(AGE_MAX);

   logic [7:0] age_q;

   // Clear wins over increment so a grant in the same cycle restarts the count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         age_q <= '0;
      end else if (clr) begin
         age_q <= '0;
      end else if (inc && (age_q != AGE_LIM)) begin
         age_q <= age_q + 8'd1;
      end
   end

   assign at_max = (age_q == AGE_LIM);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port RAM between instruction fetch, the MEM stage and
// (optionally) a free-running debug display reader. One access per cycle;
// grants are combinational, read data returns one cycle later and is routed
// by a one-deep owner register.
// Ports:
//   clk, rst  : clock and synchronous active-low reset
//   bus       : requester buses (mem_arbiter_if.slave)
//   dbg_addr  : debug display byte address
//   dbg_data  : last value read for the debug display
//   m_en, m_we, m_addr, m_wdata, m_rdata : RAM control, word addressed
// Configuration macro MEM_ARBITER_DBG_PORT_EN: when defined the debug reader
// and its starvation counter are built; otherwise dbg_data is tied to zero
// and priority is strictly MEM over IF.
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int AGE_MAX = AGE_MAX_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   mem_arbiter_if.slave               bus,
   input  logic [ADDR_W-1:0]          dbg_addr,
   output logic [DATA_W-1:0]          dbg_data,
   output logic                       m_en,
   output logic                       m_we,
   output logic [ADDR_W-WORD_LSB-1:0] m_addr,
   output logic [DATA_W-1:0]          m_wdata,
   input  logic [DATA_W-1:0]          m_rdata
);

   owner_e grant;
   owner_e owner_q;
   owner_e owner_n;

   // Byte-lane bits never reach the RAM.
   logic unused_lsbs;
   assign unused_lsbs = ^{bus.if_addr[WORD_LSB-1:0], bus.mem_addr[WORD_LSB-1:0],
                          dbg_addr[WORD_LSB-1:0]};

`ifdef MEM_ARBITER_DBG_PORT_EN
   logic              age_at_max;
   logic [DATA_W-1:0] dbg_q;

   mem_arb_age #(.AGE_MAX(AGE_MAX)) u_age (
      .clk    (clk),
      .rst    (rst),
      .clr    (grant == OWN_DBG),
      .inc    (grant != OWN_DBG),
      .at_max (age_at_max)
   );
`else
   localparam int unused_age_max = AGE_MAX;
`endif

   // Pick the single winner for this cycle. MEM is never held off; a starved
   // debug reader jumps ahead of fetch, and otherwise soaks up idle cycles.
   // Nothing is granted while reset is asserted.
   always_comb begin
      grant = OWN_NONE;
      if (rst) begin
         if (bus.mem_req) begin
            grant = OWN_MEM;
`ifdef MEM_ARBITER_DBG_PORT_EN
         end else if (age_at_max) begin
            grant = OWN_DBG;
         end else if (bus.if_req) begin
            grant = OWN_IF;
         end else begin
            grant = OWN_DBG;
`else
         end else if (bus.if_req) begin
            grant = OWN_IF;
`endif
         end
      end
   end

   // Drive the RAM from the winner; only the MEM stage can write.
   always_comb begin
      m_addr = '0;
      case (grant)
         OWN_IF:  m_addr = bus.if_addr[ADDR_W-1:WORD_LSB];
         OWN_MEM: m_addr = bus.mem_addr[ADDR_W-1:WORD_LSB];
         OWN_DBG: m_addr = dbg_addr[ADDR_W-1:WORD_LSB];
         default: m_addr = '0;
      endcase
   end

   assign m_en    = (grant != OWN_NONE);
   assign m_we    = (grant == OWN_MEM) && bus.mem_we;
   assign m_wdata = bus.mem_wdata;

   assign bus.if_gnt  = (grant == OWN_IF);
   assign bus.mem_gnt = (grant == OWN_MEM);

   // A store returns nothing, so it leaves the owner empty.
   always_comb begin
      owner_n = grant;
      if ((grant == OWN_MEM) && bus.mem_we) begin
         owner_n = OWN_NONE;
      end
   end

   // Owner of the read data arriving next cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_n;
      end
   end

   // Gating with rst drops the response of a read granted just before reset.
   assign bus.if_rvalid  = rst && (owner_q == OWN_IF);
   assign bus.mem_rvalid = rst && (owner_q == OWN_MEM);
   assign bus.if_rdata   = m_rdata;
   assign bus.mem_rdata  = m_rdata;

`ifdef MEM_ARBITER_DBG_PORT_EN
   // Capture the debug read so the display holds it between debug grants.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dbg_q <= '0;
      end else if (owner_q == OWN_DBG) begin
         dbg_q <= m_rdata;
      end
   end

   assign dbg_data = (rst && (owner_q == OWN_DBG)) ? m_rdata : dbg_q;
`else
   assign dbg_data = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a transaction-level model of the arbiter (priority rules, pending
// read, starvation age, shadow memory). Build with or without
// MEM_ARBITER_DBG_PORT_EN.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int AGE_MAX   = 8;
   localparam int RAM_WORDS = 64;

   localparam int G_NONE = 0;
   localparam int G_IF   = 1;
   localparam int G_MEM  = 2;
   localparam int G_DBG  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic              m_en;
   logic              m_we;
   logic [ADDR_W-3:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AGE_MAX(AGE_MAX)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .m_en     (m_en),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_rdata  (m_rdata)
   );

   // Initial RAM contents: word 2 holds the instruction from the fetch example.
   function automatic logic [31:0] initWord(int i);
      if (i == 2) return 32'h2009000D;
      return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
   endfunction

   // Single-port RAM with registered read data.
   logic [31:0] ram [RAM_WORDS];
   logic        preload = 1'b1;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < RAM_WORDS; i++) ram[i] <= initWord(i);
      end else if (m_en) begin
         if (m_we) ram[m_addr[5:0]] <= m_wdata;
         else      m_rdata <= ram[m_addr[5:0]];
      end
   end

   // Reference model state.
   int          exp_age;
   int          pend_own;
   logic [31:0] pend_data;
   logic [31:0] dbg_hold;
   logic [31:0] ref_mem [RAM_WORDS];
   int          cur_grant;
   bit          model_ok = 1'b0;

   function automatic int expGrant();
      if (!rst) return G_NONE;
      if (bus.mem_req) return G_MEM;
`ifdef MEM_ARBITER_DBG_PORT_EN
      if (exp_age >= AGE_MAX) return G_DBG;
      if (bus.if_req) return G_IF;
      return G_DBG;
`else
      if (bus.if_req) return G_IF;
      return G_NONE;
`endif
   endfunction

   function automatic logic [31:0] grantWord(int g);
      case (g)
         G_IF:    return bus.if_addr >> 2;
         G_MEM:   return bus.mem_addr >> 2;
         G_DBG:   return dbg_addr >> 2;
         default: return 32'd0;
      endcase
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output with what the model says this cycle must show.
   task automatic checkOutput();
      int          g;
      logic [31:0] w;
      logic [31:0] exp_dbg;
      if (!model_ok) return;
      g = expGrant();
      cur_grant = g;
      cmp("if_gnt",  32'(bus.if_gnt),  32'(g == G_IF));
      cmp("mem_gnt", 32'(bus.mem_gnt), 32'(g == G_MEM));
      cmp("m_en",    32'(m_en),        32'(g != G_NONE));
      if (g != G_NONE) begin
         w = grantWord(g);
         cmp("m_addr", 32'(m_addr), w);
         cmp("m_we", 32'(m_we), 32'((g == G_MEM) && bus.mem_we));
         if ((g == G_MEM) && bus.mem_we) cmp("m_wdata", m_wdata, bus.mem_wdata);
      end
      cmp("if_rvalid",  32'(bus.if_rvalid),  32'(rst && (pend_own == G_IF)));
      cmp("mem_rvalid", 32'(bus.mem_rvalid), 32'(rst && (pend_own == G_MEM)));
      if (rst && (pend_own == G_IF))  cmp("if_rdata",  bus.if_rdata,  pend_data);
      if (rst && (pend_own == G_MEM)) cmp("mem_rdata", bus.mem_rdata, pend_data);
      exp_dbg = (rst && (pend_own == G_DBG)) ? pend_data : dbg_hold;
      cmp("dbg_data", dbg_data, exp_dbg);
   endtask

   // Advance the model across a rising edge using this cycle's inputs.
   task automatic modelAdvance();
      int          g;
      logic [31:0] w;
      if (!rst) begin
         exp_age  = 0;
         pend_own = G_NONE;
         dbg_hold = 32'd0;
         model_ok = 1'b1;
         return;
      end
      if (!model_ok) return;
      g = expGrant();
      if (pend_own == G_DBG) dbg_hold = pend_data;
      pend_own = G_NONE;
      if (g != G_NONE) begin
         w = grantWord(g);
         if ((g == G_MEM) && bus.mem_we) begin
            ref_mem[w[5:0]] = bus.mem_wdata;
         end else begin
            pend_own  = g;
            pend_data = ref_mem[w[5:0]];
         end
      end
`ifdef MEM_ARBITER_DBG_PORT_EN
      if (g == G_DBG) exp_age = 0;
      else if (exp_age < AGE_MAX) exp_age++;
`endif
   endtask

   // One clock cycle: retire the previous edge in the model, drive, check.
   task automatic applyStimulus(input bit r, input bit ireq, input logic [31:0] iaddr,
                                input bit mreq, input bit mwe, input logic [31:0] maddr,
                                input logic [31:0] mwd, input logic [31:0] daddr);
      @(posedge clk);
      modelAdvance();
      @(negedge clk);
      rst           = r;
      bus.if_req    = ireq;
      bus.if_addr   = iaddr;
      bus.mem_req   = mreq;
      bus.mem_we    = mwe;
      bus.mem_addr  = maddr;
      bus.mem_wdata = mwd;
      dbg_addr      = daddr;
      #1;
      checkOutput();
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit          ip, mp, mw;
      logic [31:0] ia, ma, md, da;
      int          cnt;

      for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = initWord(i);
      rst = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0; bus.mem_req = 1'b0;
      bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; dbg_addr = 32'h8;

      doReset();
      preload = 1'b0;
      doReset();

      // Fetch of word 2 returns the instruction one cycle after the grant.
      applyStimulus(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
      cmp("fetch_gnt_lit", 32'(bus.if_gnt), 32'd1);
      cmp("fetch_addr_lit", 32'(m_addr), 32'd2);
      idleCycle();
      cmp("fetch_rvalid_lit", 32'(bus.if_rvalid), 32'd1);
      cmp("fetch_rdata_lit", bus.if_rdata, 32'h2009000D);

      // Store beats fetch, fetch goes next, then the stored word reads back.
      doReset();
      applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h1C, 32'h55, 32'h8);
      cmp("store_gnt_lit", 32'(bus.mem_gnt), 32'd1);
      cmp("store_if_stall_lit", 32'(bus.if_gnt), 32'd0);
      cmp("store_addr_lit", 32'(m_addr), 32'd7);
      applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
      cmp("fetch_after_store_lit", 32'(bus.if_gnt), 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1C, 32'h0, 32'h8);
      idleCycle();
      cmp("store_readback_lit", bus.mem_rdata, 32'h55);

      // Back-to-back loads return in order on consecutive cycles.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h8);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 32'h8);
      cmp("b2b_0_lit", bus.mem_rdata, 32'h1000_0000);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h8);
      cmp("b2b_1_lit", bus.mem_rdata, 32'h1000_0101);
      idleCycle();
      cmp("b2b_2_valid_lit", 32'(bus.mem_rvalid), 32'd1);
      cmp("b2b_2_lit", bus.mem_rdata, 32'h2009000D);
      idleCycle();
      cmp("b2b_end_lit", 32'(bus.mem_rvalid), 32'd0);

`ifdef MEM_ARBITER_DBG_PORT_EN
      // Fetch held busy for 20 cycles: debug still wins every 9th cycle.
      doReset();
      cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
         if (m_en && !bus.if_gnt && !bus.mem_gnt) cnt++;
         if (c == 10) cmp("dbg_after_grant_lit", dbg_data, 32'h2009000D);
      end
      cmp("dbg_grant_count_lit", 32'(cnt), 32'd2);
`else
      // Without a debug port an idle bus leaves the RAM untouched.
      doReset();
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         idleCycle();
         if (m_en) cnt++;
      end
      cmp("idle_m_en_lit", 32'(cnt), 32'd0);
      cmp("idle_dbg_lit", dbg_data, 32'd0);
`endif

      // Reset right after a fetch grant swallows the response.
      doReset();
      applyStimulus(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
      cmp("rst_no_rvalid_lit", 32'(bus.if_rvalid), 32'd0);
      cmp("rst_no_gnt_lit", 32'(m_en), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8);
      cmp("rst_dbg_zero_lit", dbg_data, 32'd0);

      // Randomized traffic: requesters hold until granted, occasionally
      // withdraw, and reset strikes now and then.
      doReset();
      ip = 1'b0; mp = 1'b0; mw = 1'b0;
      ia = '0; ma = '0; md = '0; da = 32'h8;
      for (int c = 0; c < 1500; c++) begin
         if (!ip && ($urandom_range(0, 2) == 0)) begin
            ip = 1'b1;
            ia = 32'($urandom_range(0, 255));
         end else if (ip && ($urandom_range(0, 29) == 0)) begin
            ip = 1'b0;
         end
         if (!mp && ($urandom_range(0, 3) == 0)) begin
            mp = 1'b1;
            mw = 1'($urandom_range(0, 1));
            ma = 32'($urandom_range(0, 255));
            md = $urandom;
         end else if (mp && ($urandom_range(0, 29) == 0)) begin
            mp = 1'b0;
         end
         if ($urandom_range(0, 15) == 0) da = 32'($urandom_range(0, 255));
         applyStimulus(($urandom_range(0, 99) != 0), ip, ia, mp, mw, ma, md, da);
         if (cur_grant == G_IF)  ip = 1'b0;
         if (cur_grant == G_MEM) mp = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
